// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin arbiter sharing one SDRAM controller client port among NUM_PORTS requesters
// Optional: define SDRAM_ARB_PORT0_PRIO_EN to give port 0 fixed priority over the round-robin ports.
module sdram_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int WRITE_HOLD = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            reset_l,
  input  logic [NUM_PORTS-1:0]            cli_req,
  input  logic [NUM_PORTS-1:0]            cli_rh_wl,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] cli_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] cli_data_w,
  output logic [NUM_PORTS-1:0]            cli_done,
  output logic [NUM_PORTS-1:0]            cli_rvalid,
  output logic                            cli_rerr,
  output logic [DATA_WIDTH-1:0]           cli_data_r,
  output logic                            sdram_req,
  input  logic                            sdram_ack,
  output logic [ADDR_WIDTH-1:0]           sdram_addr,
  output logic                            sdram_rh_wl,
  output logic [DATA_WIDTH-1:0]           sdram_data_w,
  input  logic [DATA_WIDTH-1:0]           sdram_data_r,
  input  logic                            sdram_data_r_en
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t               state;
  logic [IW-1:0]        ptr;       // first port examined at the next arbitration
  logic [IW-1:0]        owner;
  logic [3:0]           cnt;
  logic                 hold_ptr;
  logic [NUM_PORTS-1:0] cand;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        pick;
  logic                 found;
  logic                 win;
  logic [IW-1:0]        win_idx;
  logic                 win_prio;

  always_comb begin
    cand = cli_req;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
    cand[0] = 1'b0;
`endif
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = IW'((int'(ptr) + i) % NUM_PORTS);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    win      = found;
    win_idx  = pick;
    win_prio = 1'b0;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
    if (cli_req[0]) begin
      win      = 1'b1;
      win_idx  = '0;
      win_prio = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      cnt          <= '0;
      hold_ptr     <= 1'b0;
      cli_done     <= '0;
      cli_rvalid   <= '0;
      cli_rerr     <= 1'b0;
      cli_data_r   <= '0;
      sdram_req    <= 1'b0;
      sdram_addr   <= '0;
      sdram_rh_wl  <= 1'b0;
      sdram_data_w <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win) begin
            owner        <= win_idx;
            hold_ptr     <= win_prio;
            sdram_addr   <= cli_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            sdram_data_w <= cli_data_w[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            sdram_rh_wl  <= cli_rh_wl[win_idx];
            sdram_req    <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            cnt       <= '0;
            state     <= sdram_rh_wl ? RD_WAIT : WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (sdram_data_r_en) begin
            cli_data_r        <= sdram_data_r;
            cli_done[owner]   <= 1'b1;
            cli_rvalid[owner] <= 1'b1;
            state             <= DONE;
          end else if (cnt == 4'(RD_TIMEOUT - 1)) begin
            cli_done[owner] <= 1'b1;
            cli_rerr        <= 1'b1;
            state           <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_WAIT: begin
          if (cnt == 4'(WRITE_HOLD - 1)) begin
            cli_done[owner] <= 1'b1;
            state           <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          // Pulses last exactly one cycle; the pass through IDLE gives the controller its turnaround.
          cli_done   <= '0;
          cli_rvalid <= '0;
          cli_rerr   <= 1'b0;
          if (!hold_ptr) begin
            ptr <= (owner == IW'(NUM_PORTS - 1)) ? '0 : owner + IW'(1);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter
module tb_sdram_arbiter;
  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 16;

  logic             clk;
  logic             reset_l;
  logic [NP-1:0]    cli_req;
  logic [NP-1:0]    cli_rh_wl;
  logic [NP*AW-1:0] cli_addr;
  logic [NP*DW-1:0] cli_data_w;
  logic [NP-1:0]    cli_done;
  logic [NP-1:0]    cli_rvalid;
  logic             cli_rerr;
  logic [DW-1:0]    cli_data_r;
  logic             sdram_req;
  logic             sdram_ack;
  logic [AW-1:0]    sdram_addr;
  logic             sdram_rh_wl;
  logic [DW-1:0]    sdram_data_w;
  logic [DW-1:0]    sdram_data_r;
  logic             sdram_data_r_en;

  int n_vec = 0;
  int n_err = 0;

  sdram_arbiter dut (
    .clk             (clk),
    .reset_l         (reset_l),
    .cli_req         (cli_req),
    .cli_rh_wl       (cli_rh_wl),
    .cli_addr        (cli_addr),
    .cli_data_w      (cli_data_w),
    .cli_done        (cli_done),
    .cli_rvalid      (cli_rvalid),
    .cli_rerr        (cli_rerr),
    .cli_data_r      (cli_data_r),
    .sdram_req       (sdram_req),
    .sdram_ack       (sdram_ack),
    .sdram_addr      (sdram_addr),
    .sdram_rh_wl     (sdram_rh_wl),
    .sdram_data_w    (sdram_data_w),
    .sdram_data_r    (sdram_data_r),
    .sdram_data_r_en (sdram_data_r_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic req, input logic rh,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    cli_req[p]          = req;
    cli_rh_wl[p]        = rh;
    cli_addr[p*AW +: AW] = a;
    cli_data_w[p*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset_l         = 1'b0;
    cli_req         = '0;
    sdram_ack       = 1'b0;
    sdram_data_r_en = 1'b0;
    sdram_data_r    = '0;
    tick();
    tick();
    reset_l = 1'b1;
    tick();
  endtask

  task automatic wait_sdram_req(input string tag);
    int n = 0;
    while (!sdram_req && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(sdram_req), 1);
  endtask

  task automatic ack_once();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (cli_done == '0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    cli_rh_wl  = '0;
    cli_addr   = '0;
    cli_data_w = '0;
    do_reset();
    check("rst_req",    32'(sdram_req), 0);
    check("rst_done",   32'(cli_done), 0);
    check("rst_addr",   32'(sdram_addr), 0);
    check("rst_data_r", 32'(cli_data_r), 0);

    // single write on port 1, ack three cycles after req
    set_port(1, 1'b1, 1'b0, 24'h012345, 16'hBEEF);
    tick();
    check("wr_req",  32'(sdram_req), 1);
    check("wr_addr", 32'(sdram_addr), 'h012345);
    check("wr_data", 32'(sdram_data_w), 'hBEEF);
    check("wr_dir",  32'(sdram_rh_wl), 0);
    tick();
    check("wr_req_hold1", 32'(sdram_req), 1);
    tick();
    check("wr_req_hold2", 32'(sdram_req), 1);
    ack_once();
    check("wr_req_drop", 32'(sdram_req), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wr_done_early", 32'(cli_done), 0);
      check("wr_addr_stable", 32'(sdram_addr), 'h012345);
      check("wr_data_stable", 32'(sdram_data_w), 'hBEEF);
    end
    tick();
    check("wr_done",   32'(cli_done), 'h2);
    check("wr_rvalid", 32'(cli_rvalid), 0);
    check("wr_rerr",   32'(cli_rerr), 0);
    check("wr_addr_at_done", 32'(sdram_addr), 'h012345);
    cli_req = '0;
    tick();
    check("wr_done_clear", 32'(cli_done), 0);
    tick();
    check("wr_idle_req", 32'(sdram_req), 0);

    // read on port 2, data strobe three cycles after ack
    set_port(2, 1'b1, 1'b1, 24'h00ABCD, 16'h0000);
    tick();
    check("rd_req",  32'(sdram_req), 1);
    check("rd_dir",  32'(sdram_rh_wl), 1);
    check("rd_addr", 32'(sdram_addr), 'h00ABCD);
    ack_once();
    tick();
    check("rd_wait1", 32'(cli_done), 0);
    tick();
    check("rd_wait2", 32'(cli_done), 0);
    sdram_data_r    = 16'h5A5A;
    sdram_data_r_en = 1'b1;
    tick();
    sdram_data_r_en = 1'b0;
    sdram_data_r    = '0;
    check("rd_data",   32'(cli_data_r), 'h5A5A);
    check("rd_rvalid", 32'(cli_rvalid), 'h4);
    check("rd_done",   32'(cli_done), 'h4);
    check("rd_rerr",   32'(cli_rerr), 0);
    cli_req = '0;
    tick();
    check("rd_rvalid_clear", 32'(cli_rvalid), 0);
    sdram_data_r_en = 1'b1;
    tick();
    sdram_data_r_en = 1'b0;
    check("stray_en_rvalid", 32'(cli_rvalid), 0);
    check("stray_en_done",   32'(cli_done), 0);

    // all four ports requesting continuously
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b0, AW'(32'h100 + p), DW'(32'h1000 + p));
    for (int k = 0; k < 8; k++) begin
      wait_sdram_req("rr_req");
      check("rr_owner", 32'(sdram_addr), 32'h100 + (k % 4));
      ack_once();
      wait_done(n);
      if (k == 7) cli_req = '0;
      check("rr_done",   32'(cli_done), 32'(1) << (k % 4));
      check("rr_onehot", $countones(cli_done), 1);
    end
    tick();
    tick();
    check("rr_idle", 32'(sdram_req), 0);

    // read timeout on port 1, then port 2 write is served
    do_reset();
    set_port(1, 1'b1, 1'b1, 24'h0000A1, 16'h0000);
    set_port(2, 1'b1, 1'b0, 24'h0000B2, 16'hCAFE);
    wait_sdram_req("to_req");
    check("to_owner", 32'(sdram_addr), 'hA1);
    ack_once();
    wait_done(n);
    check("to_cycles", n, 15);
    check("to_done",   32'(cli_done), 'h2);
    check("to_rerr",   32'(cli_rerr), 1);
    check("to_rvalid", 32'(cli_rvalid), 0);
    cli_req[1] = 1'b0;
    wait_sdram_req("to_next_req");
    check("to_next_addr", 32'(sdram_addr), 'hB2);
    check("to_next_data", 32'(sdram_data_w), 'hCAFE);
    ack_once();
    wait_done(n);
    cli_req = '0;
    check("to_next_done", 32'(cli_done), 'h4);
    check("to_next_rerr", 32'(cli_rerr), 0);

    // asynchronous reset during RD_WAIT
    do_reset();
    set_port(2, 1'b1, 1'b1, 24'h0000C2, 16'h0000);
    wait_sdram_req("rst_pre_req");
    ack_once();
    sdram_data_r    = 16'h1234;
    sdram_data_r_en = 1'b1;
    tick();
    sdram_data_r_en = 1'b0;
    cli_req = '0;
    check("rst_pre_data", 32'(cli_data_r), 'h1234);
    tick();
    set_port(1, 1'b1, 1'b1, 24'h0000C1, 16'h0000);
    wait_sdram_req("rst_mid_req");
    check("rst_mid_owner", 32'(sdram_addr), 'hC1);
    ack_once();
    tick();
    tick();
    set_port(3, 1'b1, 1'b0, 24'h0000C3, 16'h0000);
    reset_l = 1'b0;
    #1;
    check("rst_async_req",    32'(sdram_req), 0);
    check("rst_async_addr",   32'(sdram_addr), 0);
    check("rst_async_dir",    32'(sdram_rh_wl), 0);
    check("rst_async_data_r", 32'(cli_data_r), 0);
    check("rst_async_done",   32'(cli_done), 0);
    tick();
    reset_l = 1'b1;
    tick();
    check("rst_grant_req",  32'(sdram_req), 1);
    check("rst_grant_addr", 32'(sdram_addr), 'hC1);
    ack_once();
    sdram_data_r    = 16'h0077;
    sdram_data_r_en = 1'b1;
    tick();
    sdram_data_r_en = 1'b0;
    cli_req = '0;
    check("rst_grant_done", 32'(cli_done), 'h2);
    check("rst_grant_data", 32'(cli_data_r), 'h0077);

`ifdef SDRAM_ARB_PORT0_PRIO_EN
    // port 0 priority over port 3
    do_reset();
    set_port(0, 1'b1, 1'b0, 24'h0000D0, 16'h0000);
    set_port(3, 1'b1, 1'b0, 24'h0000D3, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      wait_sdram_req("prio_req");
      check("prio_owner", 32'(sdram_addr), 'hD0);
      ack_once();
      wait_done(n);
      if (k == 2) cli_req[0] = 1'b0;
      check("prio_done", 32'(cli_done), 'h1);
    end
    wait_sdram_req("prio_p3_req");
    check("prio_p3_owner", 32'(sdram_addr), 'hD3);
    ack_once();
    wait_done(n);
    cli_req = '0;
    check("prio_p3_done", 32'(cli_done), 'h8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
